traffic_signal_timed: RTL

Timed two-road intersection controller: the parametrised successor of the untimed sensor-driven A/B traffic-light FSM. Adds per-phase durations counted on an external timebase strobe, minimum/maximum green, all-red clearance, a latched pedestrian request with a walk phase, and a night flashing mode. Sits between the board timebase divider and the lamp drivers; outputs are Moore-decoded from state.

---
 rtl/traffic_signal_timed.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_signal_timed.sv
// -----------------------------------------------------------------------------
// traffic_signal_timed
//
// Timed two-road intersection controller. Phase lengths are counted in ticks of
// an external timebase strobe. Provides minimum/maximum green, yellow, all-red
// clearance, a latched pedestrian request served by a walk phase, and a night
// flashing mode. Lamp outputs are Moore-decoded from the next state and
// registered, so they change on the same edge as the state.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   tick     in   one-cycle timebase strobe; timers and timed transitions
//                 advance only when high
//   TA       in   traffic present on road A
//   TB       in   traffic present on road B
//   ped_req  in   pedestrian button, level-sampled every cycle
//   flash    in   night flashing mode request
//   SA       out  road A lamp (RED=00, YELLOW=01, GREEN=10, OFF=11)
//   SB       out  road B lamp, same encoding
//   walk     out  pedestrian walk lamp
//   state_o  out  current state, for debug
// -----------------------------------------------------------------------------
module traffic_signal_timed #(
   parameter int GREEN_MIN = 10,
   parameter int GREEN_MAX = 30,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int PED_T     = 5,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       TA,
   input  logic       TB,
   input  logic       ped_req,
   input  logic       flash,
   output logic [1:0] SA,
   output logic [1:0] SB,
   output logic       walk,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      A_GREEN   = 3'd0,
      A_YELLOW  = 3'd1,
      ALLRED_AB = 3'd2,
      B_GREEN   = 3'd3,
      B_YELLOW  = 3'd4,
      ALLRED_BA = 3'd5,
      PED       = 3'd6,
      FLASH     = 3'd7
   } state_t;

   localparam logic [1:0] LAMP_RED    = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_GREEN  = 2'b10;
   localparam logic [1:0] LAMP_OFF    = 2'b11;

   // Last count value of each timed phase (a phase of N ticks ends at N-1).
   localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_T - 1);

   // Road A lamp for a given state and blink phase.
   function automatic logic [1:0] decode_sa(input state_t s, input logic b);
      logic [1:0] lamp;
      lamp = LAMP_RED;
      case (s)
         A_GREEN:  lamp = LAMP_GREEN;
         A_YELLOW: lamp = LAMP_YELLOW;
         FLASH:    lamp = b ? LAMP_YELLOW : LAMP_OFF;
         default:  lamp = LAMP_RED;
      endcase
      return lamp;
   endfunction

   // Road B lamp for a given state and blink phase.
   function automatic logic [1:0] decode_sb(input state_t s, input logic b);
      logic [1:0] lamp;
      lamp = LAMP_RED;
      case (s)
         B_GREEN:  lamp = LAMP_GREEN;
         B_YELLOW: lamp = LAMP_YELLOW;
         FLASH:    lamp = b ? LAMP_RED : LAMP_OFF;
         default:  lamp = LAMP_RED;
      endcase
      return lamp;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ped_pend_q, ped_pend_d;
   logic             blink_q, blink_d;
   logic             dir_q, dir_d;      // green served after PED: 0 = A, 1 = B

   logic             ped_eff;
   logic             green_a_go;
   logic             green_b_go;
   logic             is_green;

   // A request arriving this cycle counts immediately, not only once latched.
   assign ped_eff = ped_pend_q | ped_req;

   assign green_a_go = ((cnt_q >= GMIN_LAST) && (!TA || ped_eff)) ||
                       ((cnt_q == GMAX_LAST) && TB);
   assign green_b_go = ((cnt_q >= GMIN_LAST) && (!TB || ped_eff)) ||
                       ((cnt_q == GMAX_LAST) && TA);

   assign is_green = (state_q == A_GREEN) || (state_q == B_GREEN);

   // Next-state, timer, request latch, blink and direction.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      blink_d    = blink_q;
      ped_pend_d = ped_pend_q;

      // Flash entry is immediate and ignores the timebase.
      if (flash && (state_q != FLASH)) begin
         state_d = FLASH;
      end else begin
         unique case (state_q)
            A_GREEN:   if (tick && green_a_go) state_d = A_YELLOW;
            A_YELLOW:  if (tick && (cnt_q == YELLOW_LAST)) state_d = ALLRED_AB;
            ALLRED_AB: if (tick && (cnt_q == ALLRED_LAST)) begin
                          if (ped_eff) begin
                             state_d = PED;
                             dir_d   = 1'b1;
                          end else begin
                             state_d = B_GREEN;
                          end
                       end
            B_GREEN:   if (tick && green_b_go) state_d = B_YELLOW;
            B_YELLOW:  if (tick && (cnt_q == YELLOW_LAST)) state_d = ALLRED_BA;
            ALLRED_BA: if (tick && (cnt_q == ALLRED_LAST)) begin
                          if (ped_eff) begin
                             state_d = PED;
                             dir_d   = 1'b0;
                          end else begin
                             state_d = A_GREEN;
                          end
                       end
            PED:       if (tick && (cnt_q == PED_LAST))
                          state_d = dir_q ? B_GREEN : A_GREEN;
            FLASH:     if (!flash) state_d = ALLRED_BA;
         endcase
      end

      // Timer restarts on every state change; green saturates at its max-out.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (!(is_green && (cnt_q == GMAX_LAST))) cnt_d = cnt_q + 1'b1;
      end

      if ((state_d == FLASH) && (state_q != FLASH)) begin
         blink_d = 1'b0;
      end else if ((state_q == FLASH) && tick) begin
         blink_d = ~blink_q;
      end

      // Entry into PED serves the request; a press in the same cycle is absorbed.
      if ((state_d == PED) && (state_q != PED)) begin
         ped_pend_d = 1'b0;
      end else if (ped_req) begin
         ped_pend_d = 1'b1;
      end
   end

   // State registers and registered Moore outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= A_GREEN;
         cnt_q      <= '0;
         ped_pend_q <= 1'b0;
         blink_q    <= 1'b0;
         dir_q      <= 1'b0;
         SA         <= LAMP_GREEN;
         SB         <= LAMP_RED;
         walk       <= 1'b0;
         state_o    <= A_GREEN;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ped_pend_q <= ped_pend_d;
         blink_q    <= blink_d;
         dir_q      <= dir_d;
         SA         <= decode_sa(state_d, blink_d);
         SB         <= decode_sb(state_d, blink_d);
         walk       <= (state_d == PED);
         state_o    <= state_d;
      end
   end

endmodule
